// File: rtl/alu_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_result_fifo : first-word-fall-through queue for ALU results with     |
// |                   sticky overflow flag and saturating drop counter.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_result_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     done_aax,
   input  logic [15:0]              result_aax,
   input  logic                     clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [15:0]              out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   logic empty;
   logic full_int;
   logic pop;
   logic push;
   logic drop;
   logic wr_en;

   // Status is decoded purely from registered count so no input reaches it.
   always_comb begin
      empty    = (count_q == '0);
      full_int = (count_q == CW'(DEPTH));
      pop      = !empty && out_ready;
      push     = done_aax && (!full_int || pop);
      drop     = done_aax && full_int && !pop;
      wr_en    = push && !clr;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = 8'h00;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is never visible while empty, so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= result_aax;
      end
   end

   assign out_valid = !empty;
   assign full      = full_int;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign out_data  = empty ? 16'h0000 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_result_fifo : randomized scoreboard bench for alu_result_fifo.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_result_fifo;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          done_aax;
   logic [15:0]   result_aax;
   logic          clr;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic [CW-1:0] count;
   logic          full;
   logic          overflow;
   logic [7:0]    drop_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as a queue plus status values.
   logic [15:0] model_q[$];
   logic [15:0] sb_q[$];
   logic        m_ov;
   int          m_drop;
   int          count_max;

   alu_result_fifo #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .done_aax   (done_aax),
      .result_aax (result_aax),
      .clr        (clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .count      (count),
      .full       (full),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic flush_model();
      model_q.delete();
      sb_q.delete();
      m_ov   = 1'b0;
      m_drop = 0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_count"},     32'(count),     32'(model_q.size()));
      chk({tag, "_full"},      32'(full),      32'(model_q.size() == DEPTH));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
      chk({tag, "_overflow"},  32'(overflow),  32'(m_ov));
      chk({tag, "_drop_cnt"},  32'(drop_cnt),  32'(m_drop));
      if (model_q.size() == 0) chk({tag, "_empty_data"}, 32'(out_data), 32'h0);
      if (32'(count) > count_max) count_max = 32'(count);
   endtask

   // One clock of stimulus; called just after a rising edge.
   task automatic cycle(input logic d, input logic [15:0] data, input logic rdy,
                        input logic c, input string tag);
      bit m_pop, m_push, m_drop_ev;
      done_aax   = d;
      result_aax = data;
      out_ready  = rdy;
      clr        = c;
      m_pop      = (model_q.size() > 0) && rdy;
      m_push     = d && ((model_q.size() < DEPTH) || m_pop);
      m_drop_ev  = d && !m_push;
      @(posedge clk);
      #1;
      if (c) begin
         flush_model();
      end else begin
         if (m_pop) void'(model_q.pop_front());
         if (m_push) begin
            model_q.push_back(data);
            sb_q.push_back(data);
         end
         if (m_drop_ev) begin
            m_ov = 1'b1;
            if (m_drop < 255) m_drop++;
         end
      end
      check_state(tag);
   endtask

   // Monitor: every handshake must deliver the oldest outstanding result.
   always @(negedge clk) begin
      logic [15:0] exp_v;
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: actual=%0h required=none", out_data);
         end else begin
            exp_v = sb_q.pop_front();
            chk("sb_data", 32'(out_data), 32'(exp_v));
         end
      end
   end

   initial begin
      int issued;
      int drop_before;
      reset      = 1'b1;
      done_aax   = 1'b0;
      result_aax = 16'h0;
      clr        = 1'b0;
      out_ready  = 1'b0;
      count_max  = 0;
      flush_model();
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      reset = 1'b0;

      // Single push with consumer stalled.
      cycle(1'b1, 16'h0012, 1'b0, 1'b0, "first_push");
      chk("first_push_data", 32'(out_data), 32'h0012);
      cycle(1'b0, 16'($urandom), 1'b1, 1'b0, "drain0");

      // Fill, overflow by one, drain in order.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, "fill");
      cycle(1'b1, 16'h0005, 1'b0, 1'b0, "overfill");
      chk("overfill_drop", 32'(drop_cnt), 32'h1);
      chk("overfill_full", 32'(full), 32'h1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'($urandom), 1'b1, 1'b0, "drain1");
      chk("drained_valid", 32'(out_valid), 32'h0);

      // Push and pop together while full.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, "refill");
      cycle(1'b1, 16'h00AA, 1'b1, 1'b0, "full_pushpop");
      chk("full_pushpop_count", 32'(count), 32'h4);
      chk("full_pushpop_ov", 32'(overflow), 32'h1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 16'($urandom), 1'b1, 1'b0, "drain2");

      // Streaming across pointer wrap with a toggling consumer.
      drop_before = 32'(drop_cnt);
      count_max   = 0;
      issued      = 0;
      for (int i = 0; issued < 10; i++) begin
         if ((i % 4) != 3) begin
            cycle(1'b1, 16'(16'h0100 + issued), (i % 2) == 0, 1'b0, "stream");
            issued++;
         end else begin
            cycle(1'b0, 16'($urandom), (i % 2) == 0, 1'b0, "stream");
         end
      end
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'($urandom), 1'b1, 1'b0, "drain3");
      chk("stream_nodrop", 32'(drop_cnt), 32'(drop_before));
      chk("stream_count_le_depth", 32'(count_max <= DEPTH), 32'h1);

      // Saturating drop counter, then clear racing a push.
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, "satfill");
      for (int i = 0; i < 300; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, "sat");
      chk("sat_drop", 32'(drop_cnt), 32'hFF);
      cycle(1'b1, 16'hBEEF, 1'b0, 1'b1, "clr");
      chk("clr_count", 32'(count), 32'h0);
      chk("clr_drop", 32'(drop_cnt), 32'h0);
      cycle(1'b0, 16'($urandom), 1'b1, 1'b0, "post_clr");

      // Asynchronous reset in the middle of a clock phase.
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, "pre_rst");
      done_aax = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'h0);
      chk("async_rst_count", 32'(count), 32'h0);
      chk("async_rst_full",  32'(full), 32'h0);
      chk("async_rst_data",  32'(out_data), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      flush_model();
      check_state("after_rst");
      cycle(1'b1, 16'h0077, 1'b0, 1'b0, "rst_first_push");
      chk("rst_first_push_data", 32'(out_data), 32'h0077);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
               $urandom_range(0, 59) == 0, "rand");
      end
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'($urandom), 1'b1, 1'b0, "final_drain");
      chk("sb_empty", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
